// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the IMEM REQ/ACK handshake and
// loads IF/ID, absorbing hazard stalls and EX redirects (including mid-request ones).
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] PC,
  output logic        IFID_VALID,
  output logic [31:0] IFID_INS,
  output logic [31:0] IFID_NEXT_ADR
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  localparam logic [31:0] RST_PC = RESET_PC & ~32'h3;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_ins_q, ifid_ins_d;
  logic [31:0] ifid_next_q, ifid_next_d;
  logic        pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_ins_q, hold_ins_d;
  logic [31:0] hold_next_q, hold_next_d;

  logic [31:0] pc_inc, br_tgt;

  assign pc_inc = pc_q + 32'd4;
  assign br_tgt = BRANCH_TARGET & ~32'h3;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_ins_d   = ifid_ins_q;
    ifid_next_d  = ifid_next_q;
    pend_d       = pend_q;
    tgt_d        = tgt_q;
    hold_valid_d = hold_valid_q;
    hold_ins_d   = hold_ins_q;
    hold_next_d  = hold_next_q;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (BRANCH_TAKEN) begin
          pc_d         = br_tgt;
          ifid_valid_d = 1'b0;
          hold_valid_d = 1'b0;
        end
      end
      FETCH: begin
        if (BRANCH_TAKEN) begin
          ifid_valid_d = 1'b0;
          hold_valid_d = 1'b0;
          // Address must stay stable until ACK, so an early redirect is parked.
          if (IMEM_ACK) begin
            pc_d   = br_tgt;
            pend_d = 1'b0;
          end else begin
            tgt_d  = br_tgt;
            pend_d = 1'b1;
          end
        end else if (pend_q) begin
          ifid_valid_d = 1'b0;
          if (IMEM_ACK) begin
            pc_d   = tgt_q;
            pend_d = 1'b0;
          end
        end else if (IMEM_ACK) begin
          pc_d = pc_inc;
          if (STALL) begin
            hold_valid_d = 1'b1;
            hold_ins_d   = IMEM_DATA;
            hold_next_d  = pc_inc;
            state_d      = HOLD;
          end else begin
            ifid_valid_d = 1'b1;
            ifid_ins_d   = IMEM_DATA;
            ifid_next_d  = pc_inc;
          end
        end else if (!STALL) begin
          ifid_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (BRANCH_TAKEN) begin
          pc_d         = br_tgt;
          ifid_valid_d = 1'b0;
          hold_valid_d = 1'b0;
          state_d      = FETCH;
        end else if (!STALL) begin
          ifid_valid_d = hold_valid_q;
          ifid_ins_d   = hold_ins_q;
          ifid_next_d  = hold_next_q;
          hold_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase

    req_d = (state_d == FETCH);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= BOOT;
      pc_q         <= RST_PC;
      req_q        <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_ins_q   <= '0;
      ifid_next_q  <= '0;
      pend_q       <= 1'b0;
      tgt_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_ins_q   <= '0;
      hold_next_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_ins_q   <= ifid_ins_d;
      ifid_next_q  <= ifid_next_d;
      pend_q       <= pend_d;
      tgt_q        <= tgt_d;
      hold_valid_q <= hold_valid_d;
      hold_ins_q   <= hold_ins_d;
      hold_next_q  <= hold_next_d;
    end
  end

  assign PC            = pc_q;
  assign IMEM_ADR      = pc_q;
  assign IMEM_REQ      = req_q;
  assign IFID_VALID    = ifid_valid_q;
  assign IFID_INS      = ifid_ins_q;
  assign IFID_NEXT_ADR = ifid_next_q;

endmodule
